// File: rtl/me_result_collector_if.sv
// me_result_collector_if: result stream handshake.
// Collector drives the head entry, consumer drives ready.
interface me_result_collector_if #(
  parameter int SAD_W = 14,
  parameter int MV_W  = 4
);
  logic             res_valid;
  logic             res_ready;
  logic [SAD_W-1:0] res_sad;
  logic [MV_W-1:0]  res_mvx;
  logic [MV_W-1:0]  res_mvy;
  logic [14:0]      res_idx;

  modport master (
    output res_valid,
    output res_sad,
    output res_mvx,
    output res_mvy,
    output res_idx,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_sad,
    input  res_mvx,
    input  res_mvy,
    input  res_idx,
    output res_ready
  );
endinterface

// File: rtl/me_result_collector.sv
// me_result_collector: deserializes ME serial results,
// tags them with a block index and buffers them in a FIFO.
module me_result_collector #(
  parameter int SAD_W      = 14,
  parameter int MV_W       = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int BLK_NUM    = 32400
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sign_sad,
  input  logic                 sad_out,
  input  logic                 x_out,
  input  logic                 y_out,
  me_result_collector_if.master res,
  output logic                 frame_done,
  output logic                 frm_err,
  output logic                 ovf,
  input  logic                 ovf_clr
);
  localparam int CW  = $clog2(SAD_W);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(SAD_W - 1);
  localparam logic [CW-1:0]  CNT_MV   = CW'(MV_W);
  localparam logic [14:0]    IDX_LAST = 15'(BLK_NUM - 1);
  localparam logic [AW:0]    FCNT_MAX = AW1'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  typedef struct packed {
    logic [SAD_W-1:0] sad;
    logic [MV_W-1:0]  mvx;
    logic [MV_W-1:0]  mvy;
    logic [14:0]      idx;
  } entry_t;

  state_t state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [SAD_W-1:0] sad_sr;
  logic [MV_W-1:0]  mvx_sr;
  logic [MV_W-1:0]  mvy_sr;
  logic [14:0]      blk_idx;

  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fcnt;

  logic   shift_en, mv_en, word_done, trunc;
  logic   vld, full, pop, push, drop;
  entry_t wr_entry, head;

  assign vld  = (fcnt != '0);
  assign full = (fcnt == FCNT_MAX);
  assign pop  = vld && res.res_ready;
  assign push = word_done && (!full || pop);
  assign drop = word_done && full && !pop;

  assign wr_entry.sad = {sad_sr[SAD_W-2:0], sad_out};
  assign wr_entry.mvx = mvx_sr;
  assign wr_entry.mvy = mvy_sr;
  assign wr_entry.idx = blk_idx;

  assign head = mem[rd_ptr];

  assign res.res_valid = vld;
  assign res.res_sad   = vld ? head.sad : '0;
  assign res.res_mvx   = vld ? head.mvx : '0;
  assign res.res_mvy   = vld ? head.mvy : '0;
  assign res.res_idx   = vld ? head.idx : '0;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: a word ends on its last bit or on a dropped strobe
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (sign_sad) state_d = SHIFT;
      end
      (state_q == SHIFT): begin
        if (!sign_sad)               state_d = IDLE;
        else if (cnt_q == CNT_LAST)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: shift enables, word completion, truncation
  always_comb begin
    shift_en  = 1'b0;
    mv_en     = 1'b0;
    word_done = 1'b0;
    trunc     = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        shift_en = sign_sad;
        mv_en    = sign_sad;
      end
      (state_q == SHIFT): begin
        shift_en  = sign_sad;
        mv_en     = sign_sad && (cnt_q < CNT_MV);
        word_done = sign_sad && (cnt_q == CNT_LAST);
        trunc     = !sign_sad;
      end
      default: ;
    endcase
  end

  // Bit counter and MSB-first shift registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sad_sr <= '0;
      mvx_sr <= '0;
      mvy_sr <= '0;
    end else begin
      if (shift_en && !word_done) cnt_q <= cnt_q + 1'b1;
      else                        cnt_q <= '0;
      if (shift_en) sad_sr <= {sad_sr[SAD_W-2:0], sad_out};
      if (mv_en) begin
        mvx_sr <= {mvx_sr[MV_W-2:0], x_out};
        mvy_sr <= {mvy_sr[MV_W-2:0], y_out};
      end
    end
  end

  // Block index, frame/error pulses and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_idx    <= '0;
      frame_done <= 1'b0;
      frm_err    <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      frame_done <= word_done && (blk_idx == IDX_LAST);
      frm_err    <= trunc;
      if (word_done) begin
        if (blk_idx == IDX_LAST) blk_idx <= '0;
        else                     blk_idx <= blk_idx + 1'b1;
      end
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fcnt <= fcnt + 1'b1;
      else if (!push && pop) fcnt <= fcnt - 1'b1;
    end
  end

  // FIFO storage; contents are qualified by the occupancy count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end
endmodule

// File: tb/tb_me_result_collector.sv
// tb_me_result_collector: directed vectors plus
// hand-written multi-cycle sequences.
module tb_me_result_collector;
  localparam int SAD_W = 14;
  localparam int MV_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sign_sad = 1'b0;
  logic sad_out = 1'b0;
  logic x_out = 1'b0;
  logic y_out = 1'b0;
  logic rdy = 1'b0;
  logic ovf_clr = 1'b0;
  logic fd0, fe0, ov0;
  logic fd1, fe1, ov1;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int last_cyc = 0;

  typedef struct {
    int idx;
    int sad;
    int mvx;
    int mvy;
    int cyc;
  } obs_t;

  obs_t q0[$];
  obs_t q1[$];
  int fd0_n = 0;
  int fd1_n = 0;
  int fd1_idx = -1;
  int fd1_vld = 0;

  typedef struct {
    logic [13:0] sad;
    logic [3:0]  mx;
    logic [3:0]  my;
    int          nb;
    logic        ev;
    int          eidx;
    logic        eerr;
  } vec_t;

  vec_t tv[8];

  me_result_collector_if #(.SAD_W(SAD_W), .MV_W(MV_W)) r0 ();
  me_result_collector_if #(.SAD_W(SAD_W), .MV_W(MV_W)) r1 ();

  assign r0.res_ready = rdy;
  assign r1.res_ready = rdy;

  me_result_collector #(
    .SAD_W(SAD_W), .MV_W(MV_W),
    .FIFO_DEPTH(8), .BLK_NUM(32400)
  ) u0 (
    .clk(clk), .rst(rst),
    .sign_sad(sign_sad), .sad_out(sad_out),
    .x_out(x_out), .y_out(y_out),
    .res(r0),
    .frame_done(fd0), .frm_err(fe0),
    .ovf(ov0), .ovf_clr(ovf_clr)
  );

  me_result_collector #(
    .SAD_W(SAD_W), .MV_W(MV_W),
    .FIFO_DEPTH(8), .BLK_NUM(4)
  ) u1 (
    .clk(clk), .rst(rst),
    .sign_sad(sign_sad), .sad_out(sad_out),
    .x_out(x_out), .y_out(y_out),
    .res(r1),
    .frame_done(fd1), .frm_err(fe1),
    .ovf(ov1), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (r0.res_valid && rdy)
      q0.push_back('{int'(r0.res_idx), int'(r0.res_sad),
                     int'(r0.res_mvx), int'(r0.res_mvy), cyc});
    if (r1.res_valid && rdy)
      q1.push_back('{int'(r1.res_idx), int'(r1.res_sad),
                     int'(r1.res_mvx), int'(r1.res_mvy), cyc});
    if (fd0) fd0_n <= fd0_n + 1;
    if (fd1) begin
      fd1_n   <= fd1_n + 1;
      fd1_idx <= int'(r1.res_idx);
      fd1_vld <= int'(r1.res_valid);
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive_bit(input logic [13:0] sad,
                           input logic [3:0] mx,
                           input logic [3:0] my,
                           input int i);
    sign_sad = 1'b1;
    sad_out  = sad[13-i];
    x_out    = (i < 4) ? mx[3-i] : 1'($urandom);
    y_out    = (i < 4) ? my[3-i] : 1'($urandom);
  endtask

  task automatic send(input logic [13:0] sad,
                      input logic [3:0] mx,
                      input logic [3:0] my,
                      input int n,
                      input logic lrdy,
                      input logic lclr);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive_bit(sad, mx, my, i);
      if (i == n - 1) begin
        rdy      = lrdy;
        ovf_clr  = lclr;
        last_cyc = cyc;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    sign_sad = 1'b0;
    sad_out  = 1'b0;
    x_out    = 1'b0;
    y_out    = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    sign_sad = 1'b0;
    ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [13:0] wsad(input int k);
    return 14'(32'h100 + k * 37);
  endfunction

  initial begin
    int b, b1, f0, f1;
    int lc[3];
    logic [13:0] bs[3];

    tv[0] = '{14'h1234, 4'h5, 4'hA, 7,  1'b0, 0, 1'b1};
    tv[1] = '{14'h2A5C, 4'h9, 4'h3, 14, 1'b1, 0, 1'b0};
    tv[2] = '{14'h3FFF, 4'hF, 4'hF, 14, 1'b1, 1, 1'b0};
    tv[3] = '{14'h0000, 4'h0, 4'h0, 14, 1'b1, 2, 1'b0};
    tv[4] = '{14'h0AAA, 4'h6, 4'hC, 1,  1'b0, 0, 1'b1};
    tv[5] = '{14'h1555, 4'hA, 4'h5, 13, 1'b0, 0, 1'b1};
    tv[6] = '{14'h2001, 4'h8, 4'h1, 14, 1'b1, 3, 1'b0};
    tv[7] = '{14'h3C3C, 4'hC, 4'h3, 14, 1'b1, 4, 1'b0};
    bs[0] = 14'h0F0F;
    bs[1] = 14'h3001;
    bs[2] = 14'h2BCD;

    reset_dut();
    @(negedge clk);
    chk("rst_valid", r0.res_valid, 0);
    chk("rst_sad", r0.res_sad, 0);
    chk("rst_mvx", r0.res_mvx, 0);
    chk("rst_mvy", r0.res_mvy, 0);
    chk("rst_idx", r0.res_idx, 0);
    chk("rst_fd", fd0, 0);
    chk("rst_ferr", fe0, 0);
    chk("rst_ovf", ov0, 0);
    chk("rst_ovf1", ov1, 0);
    chk("rst_ferr1", fe1, 0);

    rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send(tv[k].sad, tv[k].mx, tv[k].my, tv[k].nb, 1'b1, 1'b0);
      idle();
      @(negedge clk);
      chk($sformatf("v%0d_valid", k), r0.res_valid, tv[k].ev);
      if (tv[k].ev) begin
        chk($sformatf("v%0d_sad", k), r0.res_sad, tv[k].sad);
        chk($sformatf("v%0d_mvx", k), r0.res_mvx, tv[k].mx);
        chk($sformatf("v%0d_mvy", k), r0.res_mvy, tv[k].my);
        chk($sformatf("v%0d_idx", k), r0.res_idx, tv[k].eidx);
      end
      chk($sformatf("v%0d_err_early", k), fe0, 0);
      @(posedge clk); @(negedge clk);
      chk($sformatf("v%0d_err", k), fe0, tv[k].eerr);
      chk($sformatf("v%0d_empty", k), r0.res_valid, 0);
      @(posedge clk); @(negedge clk);
      chk($sformatf("v%0d_err_once", k), fe0, 0);
    end

    // back-to-back words, no gap
    reset_dut();
    rdy = 1'b1;
    b = q0.size();
    for (int k = 0; k < 3; k++) begin
      send(bs[k], 4'(k + 1), 4'(12 - k), 14, 1'b1, 1'b0);
      lc[k] = last_cyc;
    end
    idle();
    repeat (3) @(negedge clk);
    chk("b2b_cnt", q0.size() - b, 3);
    for (int k = 0; k < 3; k++) begin
      if (b + k < q0.size()) begin
        chk($sformatf("b2b%0d_idx", k), q0[b+k].idx, k);
        chk($sformatf("b2b%0d_sad", k), q0[b+k].sad, bs[k]);
        chk($sformatf("b2b%0d_mvx", k), q0[b+k].mvx, k + 1);
        chk($sformatf("b2b%0d_lat", k), q0[b+k].cyc, lc[k] + 1);
      end
    end

    // backpressure, overflow, set-wins, drain, clear
    reset_dut();
    rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      send(wsad(k), 4'(k), 4'(~k), 14, 1'b0, 1'b0);
      idle();
    end
    @(negedge clk);
    chk("bp_full_noovf", ov0, 0);
    chk("bp_head_idx", r0.res_idx, 0);
    send(wsad(8), 4'(8), 4'(~8), 14, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    chk("bp_ovf_setwins", ov0, 1);
    chk("bp_hold_valid", r0.res_valid, 1);
    chk("bp_hold_sad", r0.res_sad, wsad(0));
    chk("bp_hold_idx", r0.res_idx, 0);
    repeat (3) @(negedge clk);
    chk("bp_ovf_sticky", ov0, 1);
    b = q0.size();
    @(posedge clk); #1 rdy = 1'b1;
    repeat (10) @(negedge clk);
    chk("bp_drain_cnt", q0.size() - b, 8);
    for (int k = 0; k < 8; k++) begin
      if (b + k < q0.size()) begin
        chk($sformatf("bp%0d_idx", k), q0[b+k].idx, k);
        chk($sformatf("bp%0d_sad", k), q0[b+k].sad, wsad(k));
      end
    end
    chk("bp_empty", r0.res_valid, 0);
    chk("bp_ovf_kept", ov0, 1);
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    @(negedge clk);
    chk("bp_ovf_clr", ov0, 0);
    send(wsad(9), 4'h7, 4'h2, 14, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("bp_next_valid", r0.res_valid, 1);
    chk("bp_next_idx", r0.res_idx, 9);

    // push and pop in the same cycle while full
    reset_dut();
    rdy = 1'b0;
    for (int k = 0; k < 8; k++)
      send(wsad(k), 4'(k), 4'(~k), 14, 1'b0, 1'b0);
    idle();
    b = q0.size();
    send(wsad(8), 4'h8, 4'h7, 14, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("pp_no_ovf", ov0, 0);
    repeat (12) @(negedge clk);
    chk("pp_cnt", q0.size() - b, 9);
    if (b + 8 < q0.size()) begin
      chk("pp_first_idx", q0[b].idx, 0);
      chk("pp_last_idx", q0[b+8].idx, 8);
      chk("pp_last_sad", q0[b+8].sad, wsad(8));
    end

    // frame wrap on the BLK_NUM=4 instance
    reset_dut();
    rdy = 1'b1;
    b1 = q1.size();
    f0 = fd0_n;
    f1 = fd1_n;
    for (int k = 0; k < 5; k++) begin
      send(wsad(20 + k), 4'(k), 4'(k), 14, 1'b1, 1'b0);
      idle();
      repeat (2) @(negedge clk);
    end
    chk("fw_pulses", fd1_n - f1, 1);
    chk("fw_idx", fd1_idx, 3);
    chk("fw_visible", fd1_vld, 1);
    chk("fw_cnt", q1.size() - b1, 5);
    if (b1 + 4 < q1.size()) begin
      chk("fw_w3_idx", q1[b1+3].idx, 3);
      chk("fw_w4_idx", q1[b1+4].idx, 0);
      chk("fw_w4_sad", q1[b1+4].sad, wsad(24));
    end
    chk("fw_big_nopulse", fd0_n - f0, 0);

    // reset in the middle of a word with one entry held
    reset_dut();
    rdy = 1'b0;
    send(14'h1111, 4'h1, 4'h2, 14, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("mr_held", r0.res_valid, 1);
    send(14'h2222, 4'h3, 4'h4, 5, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_bit(14'h2222, 4'h3, 4'h4, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sign_sad = 1'b0;
    @(negedge clk);
    chk("mr_valid", r0.res_valid, 0);
    chk("mr_ferr", fe0, 0);
    @(posedge clk); @(negedge clk);
    chk("mr_ferr2", fe0, 0);
    rdy = 1'b1;
    send(14'h3333, 4'h5, 4'h6, 14, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("mr_next_valid", r0.res_valid, 1);
    chk("mr_next_idx", r0.res_idx, 0);
    chk("mr_next_sad", r0.res_sad, 14'h3333);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/me_result_collector.md
Name: me_result_collector

Overview:
- Receive end of the motion-estimation engine's serial result interface (sign_sad / sad_out / x_out / y_out).
- Deserializes each 1-bit result stream into a parallel word {SAD, MV x, MV y} and tags it with a block index.
- Buffers results in a small show-ahead FIFO with a valid/ready output for the downstream bitstream/statistics stage.
- Flags framing errors, overflow and end of frame.

Parameters:
- SAD_W, 14, SAD width in bits; also the serial word length in cycles.
- MV_W, 4, width of each motion-vector component.
- FIFO_DEPTH, 8, result FIFO entries (power of 2, ≥2).
- BLK_NUM, 32400, blocks per frame (3840x2160 / 16x16).

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- rst, in, 1, synchronous active-high reset.
- sign_sad, in, 1, serial word strobe; high for the duration of one result word.
- sad_out, in, 1, serial SAD bit, MSB first.
- x_out, in, 1, serial MV x bit, MSB first.
- y_out, in, 1, serial MV y bit, MSB first.
- res_valid, out, 1, FIFO head holds a result.
- res_ready, in, 1, downstream accepts the head result.
- res_sad, out, SAD_W, SAD of the head result.
- res_mvx, out, MV_W, MV x of the head result.
- res_mvy, out, MV_W, MV y of the head result.
- res_idx, out, 15, block index of the head result.
- frame_done, out, 1, one-cycle pulse when the result for block BLK_NUM-1 is written.
- frm_err, out, 1, one-cycle pulse on a truncated word.
- ovf, out, 1, sticky overflow flag.
- ovf_clr, in, 1, clears ovf.

Behaviour:
- Reset: rst sampled high at a rising edge clears all state at that edge.
  - After reset: res_valid=0, res_sad/res_mvx/res_mvy/res_idx=0, frame_done=0, frm_err=0, ovf=0.
  - FIFO is empty, bit counter=0, block index=0, FSM=IDLE.
  - A reset mid-word or mid-frame discards the partial word and all buffered entries.
- Serial format (fixed):
  - A word occupies exactly SAD_W consecutive cycles with sign_sad=1.
  - In cycle i (0..SAD_W-1) of the word, sad_out = SAD[SAD_W-1-i].
  - For i < MV_W, x_out = MVX[MV_W-1-i] and y_out = MVY[MV_W-1-i]; for i ≥ MV_W, x_out and y_out are don't-care.
- FSM states: IDLE and SHIFT.
  - IDLE, sign_sad=1: capture bit 0, cnt←1, go to SHIFT.
  - SHIFT, sign_sad=1, cnt<SAD_W-1: shift in the bit, cnt++.
  - SHIFT, sign_sad=1, cnt=SAD_W-1: shift in the last bit, word complete, go to IDLE.
  - SHIFT, sign_sad=0: truncated word. Pulse frm_err next cycle, discard the partial word, go to IDLE. The block index does not advance.
- Back-to-back words: if sign_sad stays high in the cycle after a word completes, that cycle is bit 0 of the next word; no gap cycle is required.
- Write on complete word:
  - Push {sad, mvx, mvy, blk_idx} into the FIFO; the word is visible with res_valid=1 on the next cycle (latency 1 after the last bit).
  - blk_idx increments; at BLK_NUM-1 it wraps to 0 and frame_done pulses in the same cycle the entry becomes visible.
- FIFO:
  - Show-ahead; res_* reflect the head entry whenever res_valid=1.
  - Pop when res_valid && res_ready.
  - Simultaneous push and pop when full is legal: no overflow, count unchanged.
- Overflow: a complete word arriving while the FIFO is full and no pop occurs that cycle:
  - The word is dropped and ovf←1.
  - blk_idx still increments, so later indices stay aligned to the frame.
  - ovf clears only on rst or ovf_clr=1; if ovf_clr and a new overflow occur in the same cycle, set wins.
- res_* outputs hold their values while res_valid=1 and res_ready=0.

Test Plan:
- Single word: send SAD=14'h2A5C, MVX=4'h9, MVY=4'h3 → 14 cycles later res_valid=1 with res_sad=14'h2A5C, res_mvx=9, res_mvy=3, res_idx=0.
- Back-to-back: 3 words with no gap and res_ready=1 → three results with idx 0,1,2; each appears 1 cycle after its last bit.
- Truncation: sign_sad drops after 7 cycles → frm_err pulses once, no FIFO write; the next full word gets idx 0.
- Backpressure: res_ready=0 while 9 words are sent with FIFO_DEPTH=8 → 8 entries held, ovf=1, idx of 9th discarded = 8. Then res_ready=1 → entries 0..7 drain in order; ovf_clr → ovf=0.
- Frame wrap: BLK_NUM=4, send 5 words → frame_done pulses with idx=3; the 5th word has idx=0.
- Reset mid-word: rst at bit 5 of word 2 with 1 entry buffered → res_valid=0 next cycle; the following word gets idx=0.
